// File: rtl/demux1_4_stream.sv
// rtl/demux1_4_stream.sv - 1-to-4 stream demultiplexer with per-lane one-entry buffers and delivered-beat counters
module demux1_4_stream #(
    parameter int WIDTH = 1,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [1:0]            in_sel,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [4*WIDTH-1:0]    out_data,
    output logic [4*CNTW-1:0]     out_cnt,
    output logic                  busy
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } lane_state_t;

    lane_state_t      r_state [4];
    lane_state_t      w_state_nxt [4];
    logic [WIDTH-1:0] r_data [4];
    logic [CNTW-1:0]  r_cnt [4];

    logic [3:0]       w_valid;
    logic [3:0]       w_load;
    logic [3:0]       w_drain;
    logic             w_accept;

    // Lane occupancy flags straight from the per-lane state registers
    always_comb begin
        w_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_valid[i] = (r_state[i] == S_FULL);
        end
    end

    // Ready only looks at the addressed lane so a stalled neighbour never blocks the producer
    assign in_ready = !reset && (!w_valid[in_sel] || out_ready[in_sel]);
    assign w_accept = in_valid && in_ready;

    // Decode which lane loads this cycle and which lanes hand a beat to their consumer
    always_comb begin
        w_load  = 4'b0000;
        w_drain = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_load[i]  = w_accept && (in_sel == 2'(i));
            w_drain[i] = w_valid[i] && out_ready[i];
        end
    end

    // Per-lane next state: a load always wins, a drain empties the lane only when nothing refills it
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                S_EMPTY: begin
                    if (w_load[i]) begin
                        w_state_nxt[i] = S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_drain[i] && !w_load[i]) begin
                        w_state_nxt[i] = S_EMPTY;
                    end
                end
                default: w_state_nxt[i] = S_EMPTY;
            endcase
        end
    end

    // Lane state, payload and wrapping delivery counters; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= S_EMPTY;
                r_data[i]  <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= w_state_nxt[i];
                if (w_load[i]) begin
                    r_data[i] <= in_data;
                end
                if (w_drain[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNTW'(1);
                end
            end
        end
    end

    // Flatten per-lane registers onto the packed output buses
    always_comb begin
        out_data = '0;
        out_cnt  = '0;
        for (int i = 0; i < 4; i++) begin
            out_data[i*WIDTH +: WIDTH] = r_data[i];
            out_cnt[i*CNTW +: CNTW]    = r_cnt[i];
        end
    end

    assign out_valid = w_valid;
    assign busy      = |w_valid;

endmodule

// File: doc/demux1_4_stream.md
Name: demux1_4_stream

Overview:
- 1-to-4 stream demultiplexer: the distribution-side counterpart of the 4:1 select path.
- Each input beat carries a 2-bit lane select. The beat is steered to one of four registered output lanes under valid/ready handshake.
- Each lane holds a one-entry buffer and a wrapping count of beats delivered.
- Sits between a single producer and four independent consumers.

Parameters:
WIDTH, 1, data bits per beat
CNTW, 8, width of each per-lane delivered-beat counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
in_valid  input  1  producer has a beat
in_ready  output  1  block can accept the beat addressed by in_sel
in_data  input  WIDTH  beat payload
in_sel  input  2  destination lane 0..3
out_valid  output  4  lane i holds a beat
out_ready  input  4  consumer i takes its beat this cycle
out_data  output  4*WIDTH  lane i payload at bits [i*WIDTH +: WIDTH]
out_cnt  output  4*CNTW  lane i delivered-beat count at bits [i*CNTW +: CNTW]
busy  output  1  OR of out_valid

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset is sampled on the rising edge of clk. While reset is high:
  - out_valid = 0, out_data = 0, out_cnt = 0.
  - busy = 0 and in_ready = 0.
- Reset overrides every event in the same cycle. Any beat in flight or held in a lane is discarded and not counted.
- Per-lane state is 2 states, EMPTY (out_valid[i]=0) and FULL (out_valid[i]=1).
- in_ready is combinational: !reset & (!out_valid[in_sel] | out_ready[in_sel]). It depends only on the selected lane, so a full unselected lane never stalls the producer.
- Accept = in_valid & in_ready. On accept:
  - Lane in_sel loads in_data on that edge.
  - out_valid[in_sel] = 1 from the next cycle, giving 1-cycle latency from accept to visibility.
- Drain of lane i = out_valid[i] & out_ready[i]. On drain:
  - out_cnt[i] increments by 1, modulo 2^CNTW (all-ones wraps to 0).
  - out_valid[i] clears, unless lane i accepts a new beat on the same edge.
- Simultaneous drain and accept on the same lane:
  - The lane stays FULL and carries the new data next cycle.
  - The counter still increments.
  - Full throughput: one beat per cycle per lane.
- Accepts to lane a and drains on other lanes b≠a are independent in the same cycle. Up to 4 drains per cycle.
- out_data[i] is held stable while out_valid[i]=1 and out_ready[i]=0.
- out_data[i] keeps its last value after a drain; there is no clearing. Its value is don't-care while out_valid[i]=0.
- in_sel and in_data are ignored when in_valid=0.
- Producer rule: hold in_data/in_sel while in_valid=1 and in_ready=0. The block does not check this.
- out_ready[i] while out_valid[i]=0 has no effect; no count increment.
- busy = |out_valid, registered through the out_valid state.
- No combinational path from in_data to any output.

Test Plan:
- Reset mid-operation: hold all lanes FULL, assert reset 1 cycle -> next cycle out_valid=4'b0000, all out_cnt=0, in_ready=0 during reset.
- Steering: WIDTH=1, out_ready=4'b1111, send (sel,data) = (0,1),(1,0),(2,1),(3,1) on consecutive cycles:
  - Each lane shows out_valid exactly 1 cycle after its accept, with the matching data.
  - Final out_cnt = {1,1,1,1}.
- Backpressure: out_ready[2]=0, send to lane 2 twice:
  - First beat accepted; second sees in_ready=0 and is held.
  - out_data[2] stays at the first value.
  - Raise out_ready[2] -> second beat accepted that same cycle; out_cnt[2]=1 then 2.
- Independence: lane 2 FULL and stalled, send to lane 0 -> in_ready=1, lane 0 receives the beat, lane 2 unchanged.
- Throughput: lane 1 with out_ready=1, in_valid=1 and in_sel=1 for 10 cycles -> in_ready stays 1, out_valid[1] stays 1 from cycle 2, out_cnt[1]=10 after the last drain.
- Counter wrap: CNTW=2, deliver 5 beats to lane 3 -> out_cnt[3] sequence 1,2,3,0,1.
